// File: rtl/mcu_pkg.sv
// Shared line/byte constants and tx FSM encoding for the
// local-memory controller (host read-back and MCU receive side).
package mcu_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2,
    DONE = 2'd3
  } tx_state_t;

  function automatic int bytes_per_line(input int num_bits);
    return num_bits / BYTE_W;
  endfunction

  function automatic int offset_w(input int num_bits);
    return $clog2(num_bits / BYTE_W);
  endfunction

endpackage

// File: rtl/chunk_host_tx_byte_mux.sv
// Selects byte <offset> of a line: byte k = line[8k+7:8k].
// Shared with the MCU receive path.
module byte_mux
  import mcu_pkg::*;
#(
  parameter int NUM_BITS = 512,
  parameter int OFFSET_W = 6
) (
  input  logic [NUM_BITS-1:0] shadow,
  input  logic [OFFSET_W-1:0] offset,
  output logic [BYTE_W-1:0]   data_byte
);

  // indexed part-select, offset scaled by 8 via shift
  always_comb begin
    data_byte = shadow[{offset, 3'b000} +: BYTE_W];
  end

endmodule

// File: rtl/chunk_host_tx.sv
// Host-bound line serializer: captures one line, streams it bytewise
// over valid/ready. Optional XOR trailer byte: CHUNK_TX_CHECKSUM_EN.
module chunk_host_tx
  import mcu_pkg::*;
#(
  parameter int NUM_BITS = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] chunk_input,
  input  logic                line_write_to_host_en,
  input  logic                host_ready,
  output logic [7:0]          bram_to_host,
  output logic                host_valid,
  output logic                busy,
  output logic                done_flag
);

  localparam int BYTES    = bytes_per_line(NUM_BITS);
  localparam int OFFSET_W = offset_w(NUM_BITS);
  localparam logic [OFFSET_W-1:0] LAST = OFFSET_W'(BYTES - 1);

  tx_state_t             state_q, state_d;
  logic [OFFSET_W-1:0]   offset_q, offset_d;
  logic [NUM_BITS-1:0]   shadow_q;
  logic [BYTE_W-1:0]     data_byte;
  logic                  capture;
`ifdef CHUNK_TX_CHECKSUM_EN
  logic [BYTE_W-1:0]     csum_q;
`endif

  byte_mux #(
    .NUM_BITS (NUM_BITS),
    .OFFSET_W (OFFSET_W)
  ) u_byte_mux (
    .shadow    (shadow_q),
    .offset    (offset_q),
    .data_byte (data_byte)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state, offset advance and Moore outputs
  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    capture      = 1'b0;
    host_valid   = 1'b0;
    bram_to_host = '0;
    busy         = 1'b0;
    done_flag    = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_write_to_host_en) begin
          capture  = 1'b1;
          offset_d = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        host_valid   = 1'b1;
        busy         = 1'b1;
        bram_to_host = data_byte;
        if (host_ready) begin
          if (offset_q == LAST) begin
            offset_d = '0;
`ifdef CHUNK_TX_CHECKSUM_EN
            state_d  = CSUM;
`else
            state_d  = DONE;
`endif
          end else begin
            offset_d = offset_q + 1'b1;
          end
        end
      end
`ifdef CHUNK_TX_CHECKSUM_EN
      CSUM: begin
        host_valid   = 1'b1;
        busy         = 1'b1;
        bram_to_host = csum_q;
        if (host_ready) state_d = DONE;
      end
`endif
      DONE: begin
        busy      = 1'b1;
        done_flag = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // line shadow and byte offset; shadow only loads on accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q <= '0;
      shadow_q <= '0;
    end else begin
      offset_q <= offset_d;
      if (capture) shadow_q <= chunk_input;
    end
  end

`ifdef CHUNK_TX_CHECKSUM_EN
  // running XOR of transferred data bytes, cleared on start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (capture) begin
      csum_q <= '0;
    end else if (state_q == SEND && host_ready) begin
      csum_q <= csum_q ^ data_byte;
    end
  end
`endif

endmodule

// File: tb/tb_chunk_host_tx.sv
// Scoreboard bench for chunk_host_tx (NUM_BITS=512).
// Honours CHUNK_TX_CHECKSUM_EN when defined.
module tb_chunk_host_tx;

  localparam int NB    = 512;
  localparam int BYTES = NB / 8;
`ifdef CHUNK_TX_CHECKSUM_EN
  localparam int XF = BYTES + 1;
`else
  localparam int XF = BYTES;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] chunk;
  logic          start;
  logic          ready;
  logic [7:0]    bram_to_host;
  logic          host_valid;
  logic          busy;
  logic          done_flag;

  chunk_host_tx #(.NUM_BITS(NB)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .chunk_input           (chunk),
    .line_write_to_host_en (start),
    .host_ready            (ready),
    .bram_to_host          (bram_to_host),
    .host_valid            (host_valid),
    .busy                  (busy),
    .done_flag             (done_flag)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  int         done_cnt = 0;
  int         lines = 0;
  int         bytes_since = 0;
  int         cyc = 0;
  int         last_xfer = -10;
  bit         chk_rate = 1'b1;
  bit         chk_busy = 1'b0;
  bit         stall = 1'b0;
  logic [7:0] stall_byte;
  bit         bp_mode = 1'b0;
  int         pcnt = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] ramp(input int base);
    logic [NB-1:0] r;
    for (int k = 0; k < BYTES; k++) r[8*k +: 8] = 8'(k + base);
    return r;
  endfunction

  function automatic logic [NB-1:0] fill(input logic [7:0] b);
    logic [NB-1:0] r;
    for (int k = 0; k < BYTES; k++) r[8*k +: 8] = b;
    return r;
  endfunction

  // ready pattern driver: always 1, or 1,0,0,1 repeating
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      ready = (pcnt % 4 == 0) || (pcnt % 4 == 3);
      pcnt++;
    end else begin
      ready = 1'b1;
    end
  end

  // monitor: pops expected bytes on each handshake, checks done framing
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      bytes_since = 0;
      chk_busy    = 1'b0;
      stall       = 1'b0;
    end else begin
      if (chk_busy) begin
        check("busy_after_done", busy, 0);
        chk_busy = 1'b0;
      end
      if (stall) begin
        check("hold_valid", host_valid, 1);
        check("hold_byte", bram_to_host, stall_byte);
      end
      stall = host_valid && !ready;
      stall_byte = bram_to_host;
      if (host_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("byte", bram_to_host, e);
        end
        if (chk_rate && bytes_since > 0)
          check("rate", cyc - last_xfer, 1);
        last_xfer = cyc;
        bytes_since++;
      end
      if (done_flag) begin
        check("done_count", bytes_since, XF);
        check("done_timing", cyc - last_xfer, 1);
        check("done_valid", host_valid, 0);
        done_cnt++;
        bytes_since = 0;
        chk_busy = 1'b1;
      end
    end
  end

  task automatic push_line(input logic [NB-1:0] d);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < BYTES; k++) begin
      exp_q.push_back(d[8*k +: 8]);
      x ^= d[8*k +: 8];
    end
`ifdef CHUNK_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    lines++;
  endtask

  task automatic start_line(input logic [NB-1:0] d);
    @(posedge clk);
    #1;
    check("valid_before_start", host_valid, 0);
    chunk = d;
    start = 1'b1;
    push_line(d);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("valid_after_start", host_valid, 1);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input bit scramble, input bit spam,
                           input bit drop_in_done,
                           input logic [NB-1:0] drop_d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (scramble)
        for (int w = 0; w < NB / 32; w++) chunk[32*w +: 32] = $urandom;
      if (spam && busy && !done_flag) begin
        chunk = drop_d;
        start = (i % 7 == 3);
      end
      if (drop_in_done && done_flag) begin
        chunk = drop_d;
        start = 1'b1;
      end
      if (done_cnt >= lines && !done_flag) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!ok) check("timeout", 1, 0);
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    chunk = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", bram_to_host, 0);
    check("rst_valid", host_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_flag, 0);
    rst = 1'b0;

    // ramp 0..63, ready held high, one byte per clock
    start_line(ramp(0));
    wait_done(1'b0, 1'b0, 1'b0, '0);

    // reset after 10 bytes: abort, nothing more, restart from byte 0
    d0 = done_cnt;
    start_line(ramp(0));
    for (int i = 0; i < 200 && bytes_since < 10; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_data", bram_to_host, 0);
    check("midrst_valid", host_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done_flag, 0);
    exp_q.delete();
    lines--;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_no_done", done_cnt, d0);
    start_line(ramp(0));
    wait_done(1'b0, 1'b0, 1'b0, '0);

    // backpressure 1,0,0,1
    chk_rate = 1'b0;
    bp_mode  = 1'b1;
    start_line(ramp(8'h80));
    wait_done(1'b0, 1'b0, 1'b0, '0);
    bp_mode  = 1'b0;
    @(posedge clk);
    chk_rate = 1'b1;

    // 0x55 line with starts during SEND and DONE, then 0xAA line
    start_line(fill(8'h55));
    wait_done(1'b0, 1'b1, 1'b1, fill(8'h77));
    start_line(fill(8'hAA));
    wait_done(1'b0, 1'b0, 1'b0, '0);

    // input scrambled every cycle after capture
    start_line(ramp(8'h20));
    wait_done(1'b1, 1'b0, 1'b0, '0);

    // 0x01..0x40: XOR trailer is 0x40 when enabled
    start_line(ramp(1));
    wait_done(1'b0, 1'b0, 1'b0, '0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("line_count", done_cnt, lines);
    check("idle_valid", host_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
